// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial AND/OR/ADD/PASS unit, one bit per clock, LSB first
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sa,
  input  logic             sb,
  input  logic             c_in,
  input  logic             sm,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q, sh_d, result_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             carry_q, sm_q, busy_q, done_q, c_out_q, ovf_q;
  logic             bit_d, carry_d, last_d;
  // current bit slice: result bit, carry out of this bit and shifted result
  always_comb begin
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    bit_d   = op_q == 2'b00 ? a_q[0] & b_q[0] :
              op_q == 2'b01 ? a_q[0] | b_q[0] :
              op_q == 2'b10 ? a_q[0] ^ b_q[0] ^ carry_q : sm_q;
    sh_d    = {bit_d, sh_q[WIDTH-1:1]};
    last_d  = cnt_q == CW'(WIDTH - 1);
  end
  // FSM: accept in IDLE/DONE, shift one bit per RUN cycle, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_q + 1'b1;
      if (last_d) begin
        state_q  <= DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= sh_d;
        c_out_q  <= carry_d;
        ovf_q    <= (op_q == 2'b10) & (carry_q ^ carry_d);
      end
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        a_q     <= sa ? ~a : a;
        b_q     <= sb ? ~b : b;
        carry_q <= c_in;
        op_q    <= op;
        sm_q    <= sm;
        cnt_q   <= '0;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation; sampled only when not busy.
REQ-005 The block SHALL have ports a and b, input, WIDTH each, the operand words, sampled at accepted start.
REQ-006 The block SHALL have ports sa and sb, input, 1 each, which invert a and b respectively when high, sampled at accepted start.
REQ-007 The block SHALL have port c_in, input, 1, the initial carry into bit 0, sampled at accepted start.
REQ-008 The block SHALL have port sm, input, 1, the pass-through bit for op 11, sampled at accepted start.
REQ-009 The block SHALL have port op, input, 2, the operation select (00 AND, 01 OR, 10 ADD, 11 PASS-sm), sampled at accepted start.
REQ-010 The block SHALL have port busy, output, 1, which is high while bits are being processed.
REQ-011 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, WIDTH, the completed result word.
REQ-013 The block SHALL have port c_out, output, 1, the final carry out of bit WIDTH-1.
REQ-014 The block SHALL have port overflow, output, 1, the signed overflow flag, meaningful for op 10 only.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at an edge SHALL be accepted: the block latches A=sa?~a:a, B=sb?~b:b, carry=c_in, op, sm and the bit counter=0, then enters RUN.
REQ-017 In RUN, each edge SHALL process one bit, LSB first: bit i of the result is A&B (op 00), A|B (op 01), A^B^carry (op 10) or sm (op 11), and carry is updated to maj(A_i,B_i,carry) for every op.
REQ-018 The result bits SHALL be shifted into an internal register, and result SHALL NOT change until completion.
REQ-019 After the edge that processes bit WIDTH-1, the block SHALL enter DONE, update result, c_out and overflow together, and hold them until the next accepted start.
REQ-020 Overflow SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1) when op=10, and 0 otherwise.
REQ-021 busy SHALL be high exactly during RUN, which lasts WIDTH cycles; done SHALL be high exactly during DONE, which lasts one cycle; DONE returns to IDLE unless start=1.
REQ-022 If start=1 in the DONE cycle, the block SHALL begin a new operation back-to-back with no idle cycle, and done SHALL still pulse for that cycle.
REQ-023 start SHALL be ignored during RUN, and input changes during RUN SHALL have no effect on the operation in flight.
REQ-024 The latency SHALL be fixed: with start accepted at edge k, busy is high from edge k through edge k+WIDTH, and done is high from edge k+WIDTH to edge k+WIDTH+1.

Reset
REQ-025 When rst=1 at an edge, the FSM SHALL go to IDLE and busy, done, result, c_out, overflow, carry and the counter SHALL be cleared to 0, with rst taking priority over start.
REQ-026 A reset during RUN SHALL abort the operation, and no done pulse SHALL follow it.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, op=10, a=0x3C, b=0x05, c_in=0 -> result=0x41, c_out=0, overflow=0, with done exactly 8 cycles after the start edge and busy high for 8 cycles.
REQ-028 The bench SHALL cover: op=10, a=0x05, b=0x07, sb=1, c_in=1 (subtract) -> result=0xFE, c_out=0, overflow=0; and a=0x07, b=0x05 -> result=0x02, c_out=1.
REQ-029 The bench SHALL cover: op=10, a=0x7F, b=0x01, c_in=0 -> result=0x80, overflow=1, c_out=0; and a=0xFF, b=0x01 -> result=0x00, c_out=1, overflow=0.
REQ-030 The bench SHALL cover: op=00, a=0xF0, sa=1, b=0x3C -> result=0x0C; op=01, a=0xA0, b=0x05 -> result=0xA5; op=11, sm=1 -> result=0xFF.
REQ-031 The bench SHALL cover: start pulsed mid-RUN with different operands -> ignored, first result unchanged; start held high through DONE -> second operation starts immediately, with busy rising in the cycle after done.
REQ-032 The bench SHALL cover: rst asserted on the 4th RUN cycle -> next cycle busy=0, done=0, result=0x00, and no done pulse until a new start.
